// File: rtl/pll_reset_seq.sv
// PLL lock qualifier: synchronizes LOCK, waits STABLE_CYCLES of steady lock, then releases reset.
// Optional lock-loss counter enabled by defining PLL_RESET_LOSS_CNT_EN.
module pll_reset_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOSS_CNT_WIDTH = 8
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic pll_lock_i,
  output logic rst_n_o,
  output logic ready_o,
  output logic lock_lost_o
`ifdef PLL_RESET_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_WIDTH-1:0] lock_loss_cnt_o
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT_LOCK, STABLE, RUN} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_rst_n_o;
  logic                   r_ready;
  logic                   r_lock_lost;

  // Synchronizer: pll_lock_i is asynchronous, only the last stage is trusted
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // FSM; outputs are set on the same edge the state moves so rst_n_o tracks RUN exactly
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rst_n_o   <= 1'b0;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_rst_n_o   <= 1'b0;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state <= WAIT_LOCK;
          r_cnt   <= '0;
        end
        WAIT_LOCK: begin
          r_cnt <= '0;
          if (w_lock_s) r_state <= STABLE;
        end
        STABLE: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            r_state   <= RUN;
            r_rst_n_o <= 1'b1;
            r_ready   <= r_rst_n_o;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (w_lock_s) begin
            r_rst_n_o <= 1'b1;
            r_ready   <= r_rst_n_o;
          end else begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_lock_lost <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign rst_n_o     = r_rst_n_o;
  assign ready_o     = r_ready;
  assign lock_lost_o = r_lock_lost;

`ifdef PLL_RESET_LOSS_CNT_EN
  logic [LOSS_CNT_WIDTH-1:0] r_loss_cnt;

  function automatic logic [LOSS_CNT_WIDTH-1:0] sat_inc(input logic [LOSS_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + LOSS_CNT_WIDTH'(1);
  endfunction

  // Counts on the RUN->WAIT_LOCK edge so it moves together with lock_lost_o
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_loss_cnt <= '0;
    end else if (r_state == RUN && !w_lock_s) begin
      r_loss_cnt <= sat_inc(r_loss_cnt);
    end
  end

  assign lock_loss_cnt_o = r_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with SYNC_STAGES=2, STABLE_CYCLES=4, LOSS_CNT_WIDTH=2.
// Loss-counter checks are active when PLL_RESET_LOSS_CNT_EN is defined.
module tb_pll_reset_seq;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  logic pll_lock_i = 1'b0;
  logic rst_n_o;
  logic ready_o;
  logic lock_lost_o;
`ifdef PLL_RESET_LOSS_CNT_EN
  logic [1:0] lock_loss_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pll_reset_seq #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .LOSS_CNT_WIDTH(2)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .pll_lock_i (pll_lock_i),
    .rst_n_o    (rst_n_o),
    .ready_o    (ready_o),
    .lock_lost_o(lock_lost_o)
`ifdef PLL_RESET_LOSS_CNT_EN
    ,
    .lock_loss_cnt_o(lock_loss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input logic lock);
    rst_n      = 1'b0;
    pll_lock_i = lock;
    repeat (3) tick();
    check("rst_rst_n_o", {31'd0, rst_n_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_lock_lost", {31'd0, lock_lost_o}, 32'd0);
`ifdef PLL_RESET_LOSS_CNT_EN
    check("rst_loss_cnt", {30'd0, lock_loss_cnt_o}, 32'd0);
`endif
  endtask

  initial begin
    // Nominal release: lock sampled high from edge 1, rst_n_o high after edge 7
    do_reset(1'b0);
    rst_n      = 1'b1;
    pll_lock_i = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check($sformatf("rel_low_e%0d", e), {31'd0, rst_n_o}, 32'd0);
    end
    tick();
    check("rel_e7_rst", {31'd0, rst_n_o}, 32'd1);
    check("rel_e7_ready", {31'd0, ready_o}, 32'd0);
    tick();
    check("rel_e8_ready", {31'd0, ready_o}, 32'd1);
    check("rel_e8_lost", {31'd0, lock_lost_o}, 32'd0);

    // Loss of lock in RUN: visible two edges after the edge sampling the drop
    pll_lock_i = 1'b0;
    tick();
    check("loss_k_rst", {31'd0, rst_n_o}, 32'd1);
    tick();
    check("loss_k1_rst", {31'd0, rst_n_o}, 32'd1);
    check("loss_k1_lost", {31'd0, lock_lost_o}, 32'd0);
    tick();
    check("loss_k2_rst", {31'd0, rst_n_o}, 32'd0);
    check("loss_k2_ready", {31'd0, ready_o}, 32'd0);
    check("loss_k2_lost", {31'd0, lock_lost_o}, 32'd1);
`ifdef PLL_RESET_LOSS_CNT_EN
    check("loss_k2_cnt", {30'd0, lock_loss_cnt_o}, 32'd1);
`endif
    tick();
    check("loss_k3_lost", {31'd0, lock_lost_o}, 32'd0);
`ifdef PLL_RESET_LOSS_CNT_EN
    check("loss_k3_cnt", {30'd0, lock_loss_cnt_o}, 32'd1);
`endif

    // Reset while in RUN: no lock_lost pulse, full requalification afterwards
    pll_lock_i = 1'b1;
    repeat (10) tick();
    check("relock_rst", {31'd0, rst_n_o}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("runrst_rst", {31'd0, rst_n_o}, 32'd0);
    check("runrst_ready", {31'd0, ready_o}, 32'd0);
    check("runrst_lost", {31'd0, lock_lost_o}, 32'd0);
`ifdef PLL_RESET_LOSS_CNT_EN
    check("runrst_cnt", {30'd0, lock_loss_cnt_o}, 32'd0);
`endif
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check($sformatf("rerel_low_e%0d", e), {31'd0, rst_n_o}, 32'd0);
      check($sformatf("rerel_lost_e%0d", e), {31'd0, lock_lost_o}, 32'd0);
    end
    tick();
    check("rerel_e7_rst", {31'd0, rst_n_o}, 32'd1);

    // Lock drop seen by the FSM while counter==2 restarts qualification
    do_reset(1'b0);
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      pll_lock_i = (e >= 4 && e <= 6) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("drop_low_e%0d", e), {31'd0, rst_n_o}, 32'd0);
    end
    pll_lock_i = 1'b1;
    tick();
    check("drop_e13_rst", {31'd0, rst_n_o}, 32'd1);
    check("drop_e13_lost", {31'd0, lock_lost_o}, 32'd0);

    // Lock toggling every cycle never qualifies
    do_reset(1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      pll_lock_i = ~c[0];
      tick();
      check($sformatf("tog_rst_c%0d", c), {31'd0, rst_n_o}, 32'd0);
      check($sformatf("tog_lost_c%0d", c), {31'd0, lock_lost_o}, 32'd0);
    end

`ifdef PLL_RESET_LOSS_CNT_EN
    // Saturating 2-bit loss counter: 1,2,3,3,3
    do_reset(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pll_lock_i = 1'b1;
      repeat (10) tick();
      pll_lock_i = 1'b0;
      repeat (3) tick();
      check($sformatf("sat_lost_%0d", i), {31'd0, lock_lost_o}, 32'd1);
      check($sformatf("sat_cnt_%0d", i), {30'd0, lock_loss_cnt_o}, (i < 2) ? i + 1 : 3);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
